tensor_write_packer: RTL and testbench



---
 rtl/tensor_pkg.sv | 15 +
 rtl/tensor_write_packer.sv | 116 +++++++++++
 tb/tb_tensor_write_packer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tensor_pkg.sv
// Shared constants and types for the tensor datapath blocks.
package tensor_pkg;
    localparam int PIX_W          = 8;
    localparam int ROW_W          = 32;
    localparam int LANES          = 4;
    localparam int TENSOR_D_WIDTH = 128;

    typedef logic [ROW_W-1:0] row_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } pack_state_e;
endpackage

// File: rtl/tensor_write_packer.sv
// Packs 4 consecutive 32-bit rows into 128-bit words and writes them to tensor_ram,
// holding one completed word in staging while the read side owns the RAM.
module tensor_write_packer
    import tensor_pkg::*;
#(
    parameter int DEPTH   = 96*96,
    parameter int D_WIDTH = TENSOR_D_WIDTH,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [AW-1:0]      base_addr,
    input  logic [AW+1:0]      num_rows,
    input  logic               in_valid,
    output logic               in_ready,
    input  row_t               in_data,
    input  logic               rd_busy,
    output logic               we,
    output logic [AW-1:0]      addr_w,
    output logic [D_WIDTH-1:0] din,
    output logic               busy,
    output logic               done
);

    pack_state_e        state;
    logic [1:0]         lane;
    logic [AW+1:0]      rows_left;
    logic [D_WIDTH-1:0] asm_reg;
    logic [D_WIDTH-1:0] staging;
    logic               pending;
    logic [AW-1:0]      addr;

    logic               completes;
    logic               accept;
    logic [6:0]         shift_amt;
    logic [D_WIDTH-1:0] placed;

    // Completion depends only on lane/rows_left so in_ready never loops through in_valid.
    assign completes = (lane == 2'd3) || (rows_left == (AW+2)'(1));
    assign we        = pending & ~rd_busy;
    assign in_ready  = (state == FILL) && (rows_left != '0) && !(completes && pending && !we);
    assign accept    = in_valid & in_ready;
    assign shift_amt = {2'd3 - lane, 5'd0};
    assign placed    = asm_reg | (D_WIDTH'(in_data) << shift_amt);
    assign din       = staging;
    assign addr_w    = addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lane      <= '0;
            rows_left <= '0;
            asm_reg   <= '0;
            staging   <= '0;
            pending   <= 1'b0;
            addr      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;

            if (accept && completes) begin
                pending <= 1'b1;
            end else if (we) begin
                pending <= 1'b0;
            end

            if (we) begin
                addr <= (addr == AW'(DEPTH-1)) ? '0 : addr + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        addr      <= base_addr;
                        rows_left <= num_rows;
                        lane      <= '0;
                        asm_reg   <= '0;
                        if (num_rows == '0) begin
                            done <= 1'b1;
                        end else begin
                            busy  <= 1'b1;
                            state <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (accept) begin
                        rows_left <= rows_left - 1'b1;
                        if (completes) begin
                            staging <= placed;
                            asm_reg <= '0;
                            lane    <= '0;
                        end else begin
                            asm_reg <= placed;
                            lane    <= lane + 1'b1;
                        end
                        if (rows_left == (AW+2)'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (we) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tensor_write_packer.sv
// Directed bench for tensor_write_packer with a write scoreboard.
module tb_tensor_write_packer;
    import tensor_pkg::*;

    localparam int DEPTH = 96*96;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW+1:0] num_rows;
    logic          in_valid;
    logic          in_ready;
    row_t          in_data;
    logic          rd_busy;
    logic          we;
    logic [AW-1:0] addr_w;
    logic [127:0]  din;
    logic          busy;
    logic          done;

    typedef struct {
        logic [AW-1:0] addr;
        logic [127:0]  data;
    } wr_t;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  cycle_cnt = 0;
    int  last_we_cycle = -10;
    int  we_count = 0;
    int  rows_sent = 0;
    int  stalls = 0;

    tensor_write_packer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .num_rows(num_rows), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .rd_busy(rd_busy), .we(we), .addr_w(addr_w),
        .din(din), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic row_t row_val(input int seed, input int i);
        logic [7:0] b;
        b = 8'(seed + 4*i);
        return {b, b + 8'd1, b + 8'd2, b + 8'd3};
    endfunction

    // Scoreboard: every write cycle seen by the RAM must match the next expected word.
    always @(negedge clk) begin
        if (rst_n && we) begin
            wr_t e;
            check("we_with_rd_busy", {127'd0, rd_busy}, 128'd0);
            if (sb.size() == 0) begin
                check("unexpected_write", 128'd1, 128'd0);
            end else begin
                e = sb.pop_front();
                check("addr_w", {{(128-AW){1'b0}}, addr_w}, {{(128-AW){1'b0}}, e.addr});
                check("din", din, e.data);
            end
            we_count++;
            last_we_cycle = cycle_cnt;
        end
    end

    task automatic push_expected(input int base, input int n, input int seed);
        wr_t e;
        int  words;
        words = (n + 3) / 4;
        for (int w = 0; w < words; w++) begin
            e.addr = AW'((base + w) % DEPTH);
            e.data = '0;
            for (int l = 0; l < 4; l++) begin
                if (4*w + l < n) e.data[127-32*l -: 32] = row_val(seed, 4*w + l);
            end
            sb.push_back(e);
        end
    endtask

    task automatic do_start(input int base, input int n);
        start     = 1'b1;
        base_addr = AW'(base);
        num_rows  = (AW+2)'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_row(input row_t d);
        int waited;
        in_data  = d;
        in_valid = 1'b1;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            stalls++;
            waited++;
            @(negedge clk);
        end
        if (!in_ready) check("row_accept_timeout", 128'd0, 128'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rows_sent++;
    endtask

    task automatic wait_done(input int words_exp, input int we_before);
        int  n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            n++;
        end
        check("done_seen", {127'd0, seen}, 128'd1);
        check("done_after_last_we", 128'(cycle_cnt), 128'(last_we_cycle + 1));
        check("busy_low_at_done", {127'd0, busy}, 128'd0);
        check("write_count", 128'(we_count - we_before), 128'(words_exp));
        check("scoreboard_empty", 128'(sb.size()), 128'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int base, input int n, input int seed);
        int wb;
        wb = we_count;
        push_expected(base, n, seed);
        do_start(base, n);
        check("busy_after_start", {127'd0, busy}, 128'd1);
        for (int i = 0; i < n; i++) send_row(row_val(seed, i));
        wait_done((n + 3) / 4, wb);
    endtask

    initial begin
        int wb;
        int n;
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        num_rows  = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        rd_busy   = 1'b0;
        #1;
        check("reset_in_ready", {127'd0, in_ready}, 128'd0);
        check("reset_we", {127'd0, we}, 128'd0);
        check("reset_addr_w", 128'(addr_w), 128'd0);
        check("reset_din", din, 128'd0);
        check("reset_busy", {127'd0, busy}, 128'd0);
        check("reset_done", {127'd0, done}, 128'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] basic frame");
        stalls = 0;
        run_frame(10, 8, 0);
        check("basic_no_stall", 128'(stalls), 128'd0);

        $display("[TB] partial last word");
        run_frame(20, 6, 64);

        $display("[TB] read contention");
        wb = we_count;
        stalls = 0;
        rows_sent = 0;
        push_expected(30, 8, 128);
        do_start(30, 8);
        fork
            begin
                for (int i = 0; i < 8; i++) send_row(row_val(128, i));
            end
            begin
                n = 0;
                while (rows_sent < 4 && n < 200) begin
                    @(posedge clk);
                    #2;
                    n++;
                end
                rd_busy = 1'b1;
                repeat (5) @(posedge clk);
                #2;
                rd_busy = 1'b0;
            end
        join
        check("contention_stall_seen", {127'd0, (stalls > 0)}, 128'd1);
        wait_done(2, wb);

        $display("[TB] address wrap");
        run_frame(DEPTH - 1, 8, 32);

        $display("[TB] reset mid-frame");
        push_expected(50, 8, 96);
        do_start(50, 8);
        send_row(row_val(96, 0));
        send_row(row_val(96, 1));
        rst_n = 1'b0;
        #1;
        check("midrst_we", {127'd0, we}, 128'd0);
        check("midrst_in_ready", {127'd0, in_ready}, 128'd0);
        check("midrst_addr_w", 128'(addr_w), 128'd0);
        check("midrst_din", din, 128'd0);
        check("midrst_busy", {127'd0, busy}, 128'd0);
        check("midrst_done", {127'd0, done}, 128'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame(40, 5, 160);

        $display("[TB] empty frame");
        wb = we_count;
        do_start(0, 0);
        @(negedge clk);
        check("empty_done", {127'd0, done}, 128'd1);
        check("empty_busy", {127'd0, busy}, 128'd0);
        repeat (3) @(negedge clk);
        check("empty_no_write", 128'(we_count - wb), 128'd0);
        check("empty_done_single", {127'd0, done}, 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not end");
        $fatal(1, "[TB] timeout");
    end

endmodule
